c64_bus_arbiter: RTL and testbench
==================================

// Module: c64_bus_arbiter
// PURPOSE
//  Parametrised N-master system-bus arbiter that replaces the fixed VIC/CPU/DMA address and write muxing.
//  Divides dot_clk into phi cycles. Phase 1 always belongs to video master 0.
//  Phase 2 goes to masters 1..N-1 by fixed priority or round robin.
//  Provides C64 cycle stealing: BA drops BA_LEAD phi cycles before AEC is withheld from the CPU.
//  Sits between the masters (VIC, 6510, expansion DMA/REU) and the PLA, RAM and I/O decode.
// PARAMETERS
//  N_MASTERS     3   masters incl. video master 0 (>=2)
//  ADDR_W        16  address width
//  DATA_W        8   data width
//  DOTS_PER_PHI  8   dot_clk cycles per phi cycle (even, >=4)
//  RR_MODE       0   0 = fixed priority, lowest index wins; 1 = round robin over masters 1..N-1
//  BA_LEAD       3   phi cycles from BA low to first stolen phase 2 (>=1)
// PORTS
//  dot_clk    in   1                  sole clock
//  res_n      in   1                  asynchronous active-low reset
//  req        in   N_MASTERS          per-master request; held until ack
//  we         in   N_MASTERS          per-master write strobe, qualified by req
//  addr       in   N_MASTERS*ADDR_W   packed addresses; master i at [i*ADDR_W +: ADDR_W]
//  wdata      in   N_MASTERS*DATA_W   packed write data
//  steal_req  in   1                  video master wants phase 2 (badline/sprite)
//  bus_rdata  in   DATA_W             read data from the decode/OR tree
//  bus_addr   out  ADDR_W             address of current owner
//  bus_we     out  1                  write enable of current owner
//  bus_wdata  out  DATA_W             write data of current owner
//  grant      out  N_MASTERS          one-hot current owner, 0 when idle
//  ack        out  N_MASTERS          1-dot pulse, access completes
//  rdata      out  DATA_W             read data latched at ack
//  phi2       out  1                  0 in phase 1, 1 in phase 2
//  ba         out  1                  bus available; low = steal pending/active
//  aec        out  1                  high only while a non-video master owns phase 2
// BEHAVIOUR
//  - Reset (async, res_n=0): dot counter 0, phi2=0, ba=1, aec=0, grant=0, ack=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, RR pointer=1, state NORMAL.
//  - Dot counter 0..DOTS_PER_PHI-1 wraps. phi2=1 for counts >= DOTS_PER_PHI/2.
//  - Phase 1 (count 0): grant=1<<0 if req[0], else 0. Master 0 owns the bus for the half-cycle.
//  - Phase 2 (count DOTS_PER_PHI/2): in NORMAL/BA_LEAD, pick among masters 1..N-1 with req=1. Fixed mode: lowest index. RR mode: first at or after the pointer; after a grant, pointer = winner+1, wrapping to 1.
//  - Grant is held for the whole half-cycle; later req changes are ignored until the next boundary.
//  - BA_LEAD: a non-video master with we=1 may still win; reads are not granted (6510 RDY rule).
//  - aec=1 while a non-video master holds grant in phase 2, else 0.
//  - ack[i] pulses on the last dot of the granted half (count DOTS_PER_PHI/2-1 or DOTS_PER_PHI-1).
//  - rdata <= bus_rdata on the same edge; rdata holds its value until the next ack.
//  - Bus outputs are a registered mux of the granted master's addr/we/wdata, valid from the first dot of the half.
//  - Idle (grant=0): bus_we=0, bus_addr = addr of master 0, bus_wdata holds its value.
//  - FSM, evaluated at count 0 only:
//      NORMAL  -> BA_LEAD (ba=0, cnt=BA_LEAD) when steal_req=1
//      BA_LEAD -> cnt-1. On cnt reaching 1 -> STOLEN. If steal_req=0 -> NORMAL, ba=1.
//      STOLEN  -> phase 2 granted to master 0 (if req[0]), aec=0. If steal_req=0 -> NORMAL, ba=1.
//  - A steal_req change mid-cycle takes effect at the next count 0.
//  - Pending requests from masters 1..N-1 are never dropped; they wait for a NORMAL/BA_LEAD phase 2.
//  - An async reset mid-access aborts it; no ack is produced.
// STRUCTURE
//  - Shared package c64_bus_pkg: state encoding (ST_NORMAL, ST_BA_LEAD, ST_STOLEN), master index constants (M_VIC=0, M_CPU=1, M_DMA=2).
//  - Sub-module c64_phi_gen: dot counter, phi2, is_p1_start, is_p2_start and last-dot strobes.
//  - Arbiter FSM, RR pointer and output mux live in this module.
// TESTING
//  1 Defaults, req=3'b010 read addr 16'hD020, bus_rdata=8'h0E
//      -> grant=3'b010 in phase 2; ack[1] at count 7; rdata=8'h0E.
//  2 RR_MODE=1, req=3'b110 held 4 phi cycles
//      -> phase-2 grants alternate 1,2,1,2.
//  3 RR_MODE=0, same stimulus
//      -> master 1 always wins; master 2 never acked.
//  4 steal_req=1 at phi n
//      -> ba=0 from count 0 of phi n+1.
//      -> CPU read granted 0 times, CPU write still granted in BA_LEAD.
//      -> phase 2 of phi n+3 granted to master 0, aec=0.
//  5 steal_req dropped in STOLEN, pending CPU read
//      -> ba=1 at next count 0; CPU acked in that phi cycle's phase 2.
//  6 res_n=0 at count 5 with grant=3'b010
//      -> all outputs at reset values immediately; no ack[1].
//      -> after release, phi2 rises at count 4.

Source files
------------

// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: shared arbiter state encoding and fixed master indices for the C64 system bus
package c64_bus_pkg;
  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_BA_LEAD = 2'd1,
    ST_STOLEN  = 2'd2
  } state_t;
  localparam int M_VIC = 0;
  localparam int M_CPU = 1;
  localparam int M_DMA = 2;
endpackage

// File: rtl/c64_phi_gen.sv
// c64_phi_gen: divides dot_clk into phi cycles and pre-decodes the half-cycle boundaries
// Ports: i_dot_clk/i_res_n clock and async active-low reset; o_phi2 high in phase 2;
// o_p1_start/o_p2_start high on the dot whose closing edge opens phase 1/phase 2;
// o_last_next high on the dot whose closing edge enters the last dot of a half.
module c64_phi_gen #(
  parameter int DOTS_PER_PHI = 8
) (
  input  logic i_dot_clk,
  input  logic i_res_n,
  output logic o_phi2,
  output logic o_p1_start,
  output logic o_p2_start,
  output logic o_last_next
);
  localparam int CW = $clog2(DOTS_PER_PHI);
  localparam int H = DOTS_PER_PHI / 2;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_dot_clk or negedge i_res_n)
    if (!i_res_n) r_cnt <= '0;
    else r_cnt <= (r_cnt == CW'(DOTS_PER_PHI - 1)) ? '0 : r_cnt + CW'(1);
  // Strobes look one dot ahead so registered consumers change exactly on the boundary.
  assign o_phi2 = r_cnt >= CW'(H);
  assign o_p1_start = r_cnt == CW'(DOTS_PER_PHI - 1);
  assign o_p2_start = r_cnt == CW'(H - 1);
  assign o_last_next = (r_cnt == CW'(H - 2)) || (r_cnt == CW'(DOTS_PER_PHI - 2));
endmodule

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter: N-master C64 system-bus arbiter with phi phasing and VIC cycle stealing
// Ports: i_dot_clk/i_res_n clock and async active-low reset; i_req/i_we/i_addr/i_wdata are
// per-master requests (packed, master i at [i*W +: W]); i_steal_req asks for phase 2 for the
// video master; i_bus_rdata is decoded read data. o_bus_addr/o_bus_we/o_bus_wdata carry the
// registered owner's access; o_grant is the one-hot owner; o_ack is a 1-dot completion pulse;
// o_rdata holds read data latched at ack; o_phi2/o_ba/o_aec are the 6510-style bus phases.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int N_MASTERS    = 3,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DOTS_PER_PHI = 8,
  parameter int RR_MODE      = 0,
  parameter int BA_LEAD      = 3
) (
  input  logic                        i_dot_clk,
  input  logic                        i_res_n,
  input  logic [N_MASTERS-1:0]        i_req,
  input  logic [N_MASTERS-1:0]        i_we,
  input  logic [N_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [N_MASTERS*DATA_W-1:0] i_wdata,
  input  logic                        i_steal_req,
  input  logic [DATA_W-1:0]           i_bus_rdata,
  output logic [ADDR_W-1:0]           o_bus_addr,
  output logic                        o_bus_we,
  output logic [DATA_W-1:0]           o_bus_wdata,
  output logic [N_MASTERS-1:0]        o_grant,
  output logic [N_MASTERS-1:0]        o_ack,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_phi2,
  output logic                        o_ba,
  output logic                        o_aec
);
  localparam int PW = $clog2(N_MASTERS);
  localparam int BW = $clog2(BA_LEAD + 1) + 1;
  logic w_phi2, w_p1_start, w_p2_start, w_last_next;
  state_t r_st, w_st_nx;
  logic [BW-1:0] r_ba_cnt, w_ba_cnt_nx;
  logic [PW-1:0] r_ptr, w_ptr_nx, w_win, w_j;
  logic w_found;
  logic [N_MASTERS-1:0] r_grant, r_ack, w_elig, w_onehot, w_p2_grant, w_next_grant;
  logic [ADDR_W-1:0] r_bus_addr, w_sel_addr;
  logic [DATA_W-1:0] r_bus_wdata, w_sel_wdata, r_rdata;
  logic r_bus_we, w_sel_we;

  c64_phi_gen #(.DOTS_PER_PHI(DOTS_PER_PHI)) u_phi (
    .i_dot_clk  (i_dot_clk),
    .i_res_n    (i_res_n),
    .o_phi2     (w_phi2),
    .o_p1_start (w_p1_start),
    .o_p2_start (w_p2_start),
    .o_last_next(w_last_next)
  );

  always_ff @(posedge i_dot_clk or negedge i_res_n)
    if (!i_res_n) begin
      r_st <= ST_NORMAL;
      r_ba_cnt <= '0;
    end else begin
      r_st <= w_st_nx;
      r_ba_cnt <= w_ba_cnt_nx;
    end

  // Steal sequencing advances only on the phase-1 boundary; r_ba_cnt counts down the
  // phi cycles of warning and the steal begins when it would reach 1.
  always_comb begin
    w_st_nx = r_st;
    w_ba_cnt_nx = r_ba_cnt;
    if (w_p1_start)
      case (r_st)
        ST_NORMAL: if (i_steal_req) begin
          w_st_nx = (BA_LEAD == 1) ? ST_STOLEN : ST_BA_LEAD;
          w_ba_cnt_nx = BW'(BA_LEAD);
        end
        ST_BA_LEAD: begin
          w_st_nx = !i_steal_req ? ST_NORMAL : (r_ba_cnt <= BW'(2)) ? ST_STOLEN : ST_BA_LEAD;
          w_ba_cnt_nx = r_ba_cnt - BW'(1);
        end
        ST_STOLEN: w_st_nx = i_steal_req ? ST_STOLEN : ST_NORMAL;
        default: w_st_nx = ST_NORMAL;
      endcase
  end

  always_comb begin
    o_ba = r_st == ST_NORMAL;
    o_aec = w_phi2 & (|r_grant[N_MASTERS-1:M_CPU]);
  end

  // During the BA warning only writes may start: the 6510 cannot be halted mid-write.
  always_comb begin
    w_elig = i_req & ((r_st == ST_BA_LEAD) ? i_we : '1);
    w_elig[M_VIC] = 1'b0;
    w_found = 1'b0;
    w_win = PW'(M_CPU);
    w_j = PW'(M_CPU);
    for (int k = 0; k < N_MASTERS - 1; k++) begin
      w_j = (RR_MODE != 0) ? PW'((int'(r_ptr) + k - 1) % (N_MASTERS - 1) + 1) : PW'(k + 1);
      if (!w_found && w_elig[w_j]) begin
        w_found = 1'b1;
        w_win = w_j;
      end
    end
    w_onehot = '0;
    w_onehot[w_win] = w_found;
    w_p2_grant = (r_st == ST_STOLEN) ? {{(N_MASTERS-1){1'b0}}, i_req[M_VIC]} : w_onehot;
    w_next_grant = w_p1_start ? {{(N_MASTERS-1){1'b0}}, i_req[M_VIC]} : w_p2_grant;
    w_ptr_nx = (w_p2_start && r_st != ST_STOLEN && w_found) ?
               ((w_win == PW'(N_MASTERS - 1)) ? PW'(1) : w_win + PW'(1)) : r_ptr;
  end

  // Idle bus parks on the video master's address with writes off and data held.
  always_comb begin
    w_sel_addr = i_addr[M_VIC*ADDR_W +: ADDR_W];
    w_sel_we = 1'b0;
    w_sel_wdata = r_bus_wdata;
    for (int i = 0; i < N_MASTERS; i++)
      if (w_next_grant[i]) begin
        w_sel_addr = i_addr[i*ADDR_W +: ADDR_W];
        w_sel_we = i_we[i];
        w_sel_wdata = i_wdata[i*DATA_W +: DATA_W];
      end
  end

  always_ff @(posedge i_dot_clk or negedge i_res_n)
    if (!i_res_n) begin
      r_grant <= '0;
      r_ack <= '0;
      r_rdata <= '0;
      r_bus_addr <= '0;
      r_bus_we <= 1'b0;
      r_bus_wdata <= '0;
      r_ptr <= PW'(1);
    end else begin
      if (w_p1_start || w_p2_start) begin
        r_grant <= w_next_grant;
        r_bus_addr <= w_sel_addr;
        r_bus_we <= w_sel_we;
        r_bus_wdata <= w_sel_wdata;
      end
      r_ack <= w_last_next ? r_grant : '0;
      if (w_last_next && |r_grant) r_rdata <= i_bus_rdata;
      r_ptr <= w_ptr_nx;
    end

  assign o_grant = r_grant;
  assign o_ack = r_ack;
  assign o_rdata = r_rdata;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_we = r_bus_we;
  assign o_bus_wdata = r_bus_wdata;
  assign o_phi2 = w_phi2;
endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb_c64_bus_arbiter: fixed-priority and round-robin arbiters against a phi-level reference model
module tb_c64_bus_arbiter;
  import c64_bus_pkg::*;
  localparam int N = 3, AW = 16, DW = 8, D = 8, H = D / 2, LEAD = 3;
  localparam logic [41:0] RST_VEC = {3'b0, 3'b0, 8'h0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0};
  logic clk = 1'b0, res_n = 1'b1, steal = 1'b0, rnd = 1'b0;
  logic [DW-1:0] brd = '0;
  logic [N-1:0] req [2], we [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wdata [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2], d_rdata [2];
  logic [N-1:0] d_grant [2], d_ack [2];
  logic d_we [2], d_phi2 [2], d_ba [2], d_aec [2];
  int mdot, run, n_cmp = 0, n_bad = 0;
  int last [2];
  logic [N-1:0] mg [2], ma [2];
  logic [DW-1:0] mrd [2], mwd [2];
  logic [AW-1:0] mad [2];
  logic mwe [2];

  always #5 clk = ~clk;

  c64_bus_arbiter #(.RR_MODE(0)) u_fix (
    .i_dot_clk(clk), .i_res_n(res_n), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .i_steal_req(steal), .i_bus_rdata(brd), .o_bus_addr(d_addr[0]),
    .o_bus_we(d_we[0]), .o_bus_wdata(d_wdata[0]), .o_grant(d_grant[0]), .o_ack(d_ack[0]),
    .o_rdata(d_rdata[0]), .o_phi2(d_phi2[0]), .o_ba(d_ba[0]), .o_aec(d_aec[0]));

  c64_bus_arbiter #(.RR_MODE(1)) u_rr (
    .i_dot_clk(clk), .i_res_n(res_n), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .i_steal_req(steal), .i_bus_rdata(brd), .o_bus_addr(d_addr[1]),
    .o_bus_we(d_we[1]), .o_bus_wdata(d_wdata[1]), .o_grant(d_grant[1]), .o_ack(d_ack[1]),
    .o_rdata(d_rdata[1]), .o_phi2(d_phi2[1]), .o_ba(d_ba[1]), .o_aec(d_aec[1]));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] dvec(int m);
    return {d_grant[m], d_ack[m], d_rdata[m], d_addr[m], d_we[m], d_wdata[m], d_phi2[m], d_ba[m], d_aec[m]};
  endfunction

  function automatic logic [41:0] mvec(int m);
    return {mg[m], ma[m], mrd[m], mad[m], mwe[m], mwd[m], 1'(mdot >= H), 1'(run == 0),
            1'((mdot >= H) && (mg[m][N-1:1] != 0))};
  endfunction

  task automatic model_reset();
    mdot = 0;
    run = 0;
    for (int m = 0; m < 2; m++) begin
      last[m] = N - 1;
      mg[m] = '0; ma[m] = '0; mrd[m] = '0; mwd[m] = '0; mad[m] = '0; mwe[m] = 1'b0;
    end
  endtask

  task automatic load(int m, logic [N-1:0] g);
    mg[m] = g;
    mad[m] = addr[m][AW-1:0];
    mwe[m] = 1'b0;
    for (int i = 0; i < N; i++)
      if (g[i]) begin
        mad[m] = addr[m][i*AW +: AW];
        mwe[m] = we[m][i];
        mwd[m] = wdata[m][i*DW +: DW];
      end
  endtask

  // run = number of consecutive phi boundaries that saw steal_req high
  task automatic model_edge();
    int nd;
    logic [N-1:0] g;
    nd = (mdot + 1) % D;
    if (nd == 0) run = steal ? run + 1 : 0;
    for (int m = 0; m < 2; m++) begin
      if (nd == 0) load(m, {{(N-1){1'b0}}, req[m][0]});
      else if (nd == H) begin
        g = '0;
        if (run >= LEAD) g[0] = req[m][0];
        else
          for (int k = 1; k < N; k++) begin
            int i;
            i = (m == 1) ? (last[m] + k - 1) % (N - 1) + 1 : k;
            if (g == 0 && req[m][i] && (run == 0 || we[m][i])) begin
              g[i] = 1'b1;
              last[m] = i;
            end
          end
        load(m, g);
      end
      ma[m] = (nd == H - 1 || nd == D - 1) ? mg[m] : '0;
      if (ma[m] != 0) mrd[m] = brd;
    end
    mdot = nd;
  endtask

  task automatic pulse_reset();
    res_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) chk($sformatf("async_reset dut%0d", m), dvec(m), mvec(m));
    #1 res_n = 1'b1;
  endtask

  task automatic drive_random();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        if (ma[m][i]) req[m][i] = 1'b0;
        if (!req[m][i] && $urandom_range(3) == 0) begin
          req[m][i] = 1'b1;
          we[m][i] = 1'($urandom_range(1));
          addr[m][i*AW +: AW] = AW'($urandom);
          wdata[m][i*DW +: DW] = DW'($urandom);
        end
      end
    brd = DW'($urandom);
    if ($urandom_range(46) == 0) steal = ~steal;
    if ($urandom_range(700) == 0) pulse_reset();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    for (int m = 0; m < 2; m++) chk($sformatf("cycle dot%0d dut%0d", mdot, m), dvec(m), mvec(m));
    if (rnd) drive_random();
  endtask

  task automatic step_to(int c);
    int k = 0;
    do begin
      step();
      k++;
    end while (mdot != c && k < 2 * D);
    if (mdot != c) chk("step_to_bound", 64'(mdot), 64'(c));
  endtask

  task automatic set_all(logic [N-1:0] r, logic [N-1:0] w);
    for (int m = 0; m < 2; m++) begin
      req[m] = r;
      we[m] = w;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; we[m] = '0; addr[m] = '0; wdata[m] = '0;
      addr[m][M_CPU*AW +: AW] = 16'h0800;
      addr[m][M_DMA*AW +: AW] = 16'hDF00;
    end
    model_reset();
    #2 res_n = 1'b0;
    #20 res_n = 1'b1;
    chk("reset_fix", dvec(0), RST_VEC);
    chk("reset_rr", dvec(1), RST_VEC);
    // CPU and DMA both reading for 4 phi cycles
    set_all(3'b110, 3'b000);
    brd = 8'h3C;
    for (int c = 0; c < 4; c++) begin
      step_to(H);
      chk("fix_p2_grant", d_grant[0], 3'b010);
      chk("rr_p2_grant", d_grant[1], (c % 2) ? 3'b100 : 3'b010);
      step_to(D - 1);
      chk("fix_ack", d_ack[0], 3'b010);
      chk("rr_ack", d_ack[1], (c % 2) ? 3'b100 : 3'b010);
    end
    // single CPU read of $D020
    set_all(3'b010, 3'b000);
    for (int m = 0; m < 2; m++) addr[m][M_CPU*AW +: AW] = 16'hD020;
    brd = 8'h0E;
    step_to(H);
    chk("read_grant", d_grant[0], 3'b010);
    chk("read_addr", d_addr[1], 16'hD020);
    chk("read_aec", d_aec[0], 1'b1);
    step_to(D - 1);
    chk("read_ack", d_ack[0], 3'b010);
    chk("read_rdata", d_rdata[0], 8'h0E);
    chk("read_rdata_rr", d_rdata[1], 8'h0E);
    // steal request raised in phi n with a CPU read pending
    set_all(3'b011, 3'b000);
    for (int m = 0; m < 2; m++) begin
      addr[m][AW-1:0] = 16'h1000;
      addr[m][M_CPU*AW +: AW] = 16'hD021;
    end
    steal = 1'b1;
    step_to(0);
    chk("ba_low_n1", d_ba[0], 1'b0);
    step_to(H);
    chk("lead_read_blocked", d_grant[0], 3'b000);
    chk("lead_read_blocked_rr", d_grant[1], 3'b000);
    for (int m = 0; m < 2; m++) begin
      we[m][M_CPU] = 1'b1;
      wdata[m][M_CPU*DW +: DW] = 8'h55;
      addr[m][M_CPU*AW +: AW] = 16'h0400;
    end
    step_to(0);
    chk("ba_low_n2", d_ba[1], 1'b0);
    step_to(H);
    chk("lead_write_grant", d_grant[0], 3'b010);
    chk("lead_write_bus", {d_we[0], d_wdata[0], d_addr[0]}, {1'b1, 8'h55, 16'h0400});
    step_to(D - 1);
    chk("lead_write_ack", d_ack[0], 3'b010);
    for (int m = 0; m < 2; m++) begin
      we[m][M_CPU] = 1'b0;
      addr[m][M_CPU*AW +: AW] = 16'hD022;
    end
    step_to(0);
    chk("ba_low_n3", d_ba[0], 1'b0);
    step_to(H);
    chk("stolen_grant", d_grant[0], 3'b001);
    chk("stolen_aec", d_aec[0], 1'b0);
    chk("stolen_addr", d_addr[1], 16'h1000);
    step_to(D - 1);
    steal = 1'b0;
    step_to(0);
    chk("ba_release", d_ba[0], 1'b1);
    step_to(H);
    chk("release_grant", d_grant[1], 3'b010);
    step_to(D - 1);
    chk("release_ack", d_ack[0], 3'b010);
    // async reset mid-access
    set_all(3'b010, 3'b000);
    step_to(H);
    chk("abort_grant", d_grant[0], 3'b010);
    step_to(H + 1);
    res_n = 1'b0;
    #1;
    chk("abort_reset_lit", dvec(0), RST_VEC);
    model_reset();
    for (int m = 0; m < 2; m++) chk("abort_reset_model", dvec(m), mvec(m));
    #1 res_n = 1'b1;
    for (int c = 1; c < D - 1; c++) begin
      step();
      chk("abort_no_ack", d_ack[0], 3'b000);
      if (c == H - 1) chk("phi2_low", d_phi2[0], 1'b0);
      if (c == H) chk("phi2_rise", d_phi2[0], 1'b1);
    end
    set_all(3'b000, 3'b000);
    rnd = 1'b1;
    repeat (4000) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
